// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
//   Definitions shared between the TPU core and its operand loader: default
//   matrix geometry, operand width, RAM address width, and the loader FSM
//   state encoding.
// -----------------------------------------------------------------------------
package tpu_pkg;

  // Default geometry shared with the TPU core.
  localparam int unsigned TPU_DIM    = 4;
  localparam int unsigned TPU_DATA_W = 8;
  localparam int unsigned TPU_ADDR_W = 4;

  // Loader sequencing: weights, then activations, then kick the core and
  // wait for it to finish before accepting the next frame.
  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_X = 2'd1,
    FIRE   = 2'd2,
    WAIT   = 2'd3
  } loader_state_e;

  // Number of operand words in one DIM x DIM matrix.
  function automatic int unsigned matrix_words(input int unsigned dim);
    return dim * dim;
  endfunction

endpackage : tpu_pkg

// File: rtl/frame_counter.sv
// -----------------------------------------------------------------------------
// frame_counter
//   Word counter for one DIM x DIM matrix. Counts accepted beats from 0 up to
//   DIM*DIM-1 and raises a terminal-count flag on the last word. It holds at
//   the terminal count rather than wrapping; the owner clears it explicitly.
//
// Ports
//   clk    in   clock, rising edge
//   res    in   asynchronous active-high reset
//   clr_i  in   synchronous clear (wins over en_i)
//   en_i   in   advance by one word
//   cnt_o  out  current word index within the matrix
//   tc_o   out  cnt_o == DIM*DIM-1
// -----------------------------------------------------------------------------
module frame_counter
  import tpu_pkg::*;
#(
  parameter int unsigned ADDR_W = TPU_ADDR_W,
  parameter int unsigned DIM    = TPU_DIM
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] cnt_o,
  output logic              tc_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(matrix_words(DIM) - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  assign tc_o  = (cnt_q == LAST_IDX);
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      // Saturate at the terminal count so the index can never step past
      // the end of the matrix even if the owner forgets to clear.
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : frame_counter

// File: rtl/tpu_operand_loader.sv
// -----------------------------------------------------------------------------
// tpu_operand_loader
//   Upstream feeder for the TPU core. Takes a framed valid/ready stream of
//   2*DIM*DIM operand words: the first DIM*DIM go to the weight RAM, the next
//   DIM*DIM to the activation RAM. After the final (in_last) word it pulses
//   tpu_start for one cycle and stalls the stream until tpu_done.
//
//   A misplaced or missing in_last raises the sticky frame_err flag; the
//   offending word is still written, and loading restarts from weight word 0
//   without starting the core.
//
// Ports
//   clk        in   clock, rising edge
//   res        in   asynchronous active-high reset
//   in_valid   in   stream word valid
//   in_ready   out  loader can accept a word this cycle
//   in_data    in   operand word, row-major
//   in_last    in   final word of the frame
//   wr_en_w    out  weight RAM write strobe (registered)
//   wr_en_x    out  activation RAM write strobe (registered)
//   wr_addr    out  RAM write address (registered)
//   wr_data    out  RAM write data (registered)
//   tpu_start  out  one-cycle start pulse to the core
//   tpu_done   in   core finished (level or pulse), honoured only in WAIT
//   frame_err  out  sticky framing-error flag, cleared only by res
//   busy       out  low only when idle at the start of a frame
// -----------------------------------------------------------------------------
module tpu_operand_loader
  import tpu_pkg::*;
#(
  parameter int unsigned DATA_W = TPU_DATA_W,
  parameter int unsigned DIM    = TPU_DIM,
  parameter int unsigned ADDR_W = TPU_ADDR_W   // 2**ADDR_W >= DIM*DIM
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              wr_en_w,
  output logic              wr_en_x,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              tpu_start,
  input  logic              tpu_done,
  output logic              frame_err,
  output logic              busy
);

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  loader_state_e     state_q,     state_d;
  logic              wr_en_w_q,   wr_en_w_d;
  logic              wr_en_x_q,   wr_en_x_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;
  logic              tpu_start_q, tpu_start_d;
  logic              frame_err_q, frame_err_d;

  // ---------------------------------------------------------------------------
  // Word counter
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] cnt;
  logic              cnt_tc;
  logic              cnt_clr;
  logic              accept;

  frame_counter #(
    .ADDR_W (ADDR_W),
    .DIM    (DIM)
  ) u_frame_counter (
    .clk   (clk),
    .res   (res),
    .clr_i (cnt_clr),
    .en_i  (accept),
    .cnt_o (cnt),
    .tc_o  (cnt_tc)
  );

  // ---------------------------------------------------------------------------
  // Handshake and framing decode
  // ---------------------------------------------------------------------------
  logic final_beat;   // current word is the last activation word
  logic last_err;     // accepted word has in_last in the wrong place

  assign in_ready   = (state_q == LOAD_W) || (state_q == LOAD_X);
  assign accept     = in_valid && in_ready;
  assign final_beat = (state_q == LOAD_X) && cnt_tc;
  assign last_err   = accept && (in_last != final_beat);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_clr     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_w_d   = accept && (state_q == LOAD_W);
    wr_en_x_d   = accept && (state_q == LOAD_X);
    tpu_start_d = accept && final_beat && in_last;
    frame_err_d = frame_err_q || last_err;

    // Address/data only move on an accepted word; strobes qualify them.
    if (accept) begin
      wr_addr_d = cnt;
      wr_data_d = in_data;
    end

    unique case (state_q)
      LOAD_W: begin
        if (accept) begin
          if (last_err) begin
            cnt_clr = 1'b1;           // restart the frame from weight word 0
          end else if (cnt_tc) begin
            state_d = LOAD_X;
            cnt_clr = 1'b1;
          end
        end
      end
      LOAD_X: begin
        if (accept) begin
          if (last_err) begin
            state_d = LOAD_W;         // abandon the frame without firing
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            state_d = FIRE;
            cnt_clr = 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tpu_done) begin
          state_d = LOAD_W;
        end
      end
      default: begin
        state_d = LOAD_W;
        cnt_clr = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= LOAD_W;
      wr_en_w_q   <= 1'b0;
      wr_en_x_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tpu_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_w_q   <= wr_en_w_d;
      wr_en_x_q   <= wr_en_x_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tpu_start_q <= tpu_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wr_en_w   = wr_en_w_q;
  assign wr_en_x   = wr_en_x_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign tpu_start = tpu_start_q;
  assign frame_err = frame_err_q;
  assign busy      = !((state_q == LOAD_W) && (cnt == '0));

endmodule : tpu_operand_loader
